// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the
// single-port data memory.
//   slave  : arbiter side (takes requests, drives grants/acks and memory controls)
//   master : requester + memory side (drives requests and memory read data)
interface dmem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic [1:0]    err;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, ack, rdata, err, busy, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, ack, rdata, err, busy, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port 16-bit data memory shared
// by requester 0 (CPU load/store) and requester 1 (debug/DMA loader).
// Each accepted command takes one ACC cycle at the memory and one RESP cycle
// carrying the ack, so a back-to-back stream runs at one access per 2 cycles.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave -- req/lock/we/addr/wdata in,
//                gnt (combinational), ack/rdata/err/busy out, memory controls
// Build option: define DMEM_ARB_BOUNDS_EN to suppress memory access for
// addresses >= DEPTH and flag them on err with the ack.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 24,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr_ptr;
    logic          r_owner;
    logic          r_cmd_we;
    logic [AW-1:0] r_cmd_addr;
    logic [DW-1:0] r_cmd_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic [1:0]    w_gnt;
    logic          w_win;
    logic          w_accept;
    logic          w_oob;
    logic          w_mem_we;
    logic          w_mem_re;
    logic [1:0]    w_ack;

    // Out-of-range only matters when the bounds check is built in.
    assign w_oob = BOUNDS_EN && (r_cmd_addr >= AW'(DEPTH));

    // Grant: pointer holder first, otherwise the other requester; never in ACC.
    always_comb begin
        w_gnt = 2'b00;
        w_win = r_rr_ptr;
        if (r_state != ACC) begin
            if (bus.req[r_rr_ptr]) begin
                w_win          = r_rr_ptr;
                w_gnt[r_rr_ptr] = 1'b1;
            end else if (bus.req[~r_rr_ptr]) begin
                w_win            = ~r_rr_ptr;
                w_gnt[~r_rr_ptr] = 1'b1;
            end
        end
    end

    assign w_accept = |w_gnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory/ack strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_ack       = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ACC;
                end
            end
            ACC: begin
                w_mem_we    = r_cmd_we & ~w_oob;
                w_mem_re    = ~r_cmd_we & ~w_oob;
                w_state_nxt = RESP;
            end
            RESP: begin
                w_ack[r_owner] = 1'b1;
                w_state_nxt    = w_accept ? ACC : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command capture, round-robin pointer and read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner     <= w_win;
                r_cmd_we    <= bus.we[w_win];
                r_cmd_addr  <= w_win ? bus.addr1 : bus.addr0;
                r_cmd_wdata <= w_win ? bus.wdata1 : bus.wdata0;
                // A locked winner keeps priority for its next command.
                r_rr_ptr    <= bus.lock[w_win] ? w_win : ~w_win;
            end
            if (r_state == ACC) begin
                r_rdata <= (r_cmd_we || w_oob) ? '0 : bus.mem_rdata;
                r_err   <= w_oob;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.ack       = w_ack;
    assign bus.err       = w_ack & {2{r_err}};
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state != IDLE);
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_addr  = r_cmd_addr;
    assign bus.mem_wdata = r_cmd_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 64-word memory model behind the
// arbiter, a queue of expected responses filled at each accept and drained by
// an ack monitor, a vector table of single transactions, and hand-written
// sequences for reset abort, round-robin alternation and lock bursts.
module tb_dmem_arbiter;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 24;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: synchronous write, combinational read.
    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    function automatic logic [15:0] init_val(input int i);
        case (i)
            1:       return 16'h0023;
            2:       return 16'h0009;
            3:       return 16'h0031;
            4:       return 16'h00C9;
            5:       return 16'h003C;
            default: return 16'(16'h4000 + i);
        endcase
    endfunction

    typedef struct {
        logic [1:0]  id;
        int          cyc;
        logic [15:0] rdata;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_we   = 0;
    int   n_re   = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.mem_we) n_we <= n_we + 1;
        if (bus.mem_re) n_re <= n_re + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ack monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.ack != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                e = q.pop_front();
                chk("ack_owner", 32'(bus.ack), 32'(e.id));
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
                chk("ack_err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic push_raw(input logic [1:0] id, input logic [15:0] rd, input logic [1:0] er);
        exp_t e;
        e.id    = id;
        e.cyc   = cyc + 2;
        e.rdata = rd;
        e.err   = er;
        q.push_back(e);
    endtask

    // Expected response from the reference memory; writes update it.
    task automatic push_model(input int id, input logic w, input logic [15:0] a, input logic [15:0] d);
        logic       oob;
        logic [1:0] oh;
        oob = BOUNDS && (a >= 16'(DEPTH));
        oh  = (id == 0) ? 2'b01 : 2'b10;
        if (w) begin
            if (!oob) ref_mem[a[5:0]] = d;
            push_raw(oh, 16'h0000, oob ? oh : 2'b00);
        end else begin
            push_raw(oh, oob ? 16'h0000 : ref_mem[a[5:0]], oob ? oh : 2'b00);
        end
    endtask

    // One cycle of stimulus; g is the grant that the next rising edge accepts.
    task automatic drive(input logic [1:0] r, input logic [1:0] lk, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input bit sb, output logic [1:0] g);
        @(negedge clk);
        bus.req    = r;
        bus.lock   = lk;
        bus.we     = w;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
        #1;
        g = bus.gnt;
        if (sb) begin
            if (g == 2'b01)      push_model(0, w[0], a0, d0);
            else if (g == 2'b10) push_model(1, w[1], a1, d1);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    vec_t        tab [9];
    logic [1:0]  g;
    int          order[$];
    int          kk;
    bit          got1;
    bit          got;
    int          nwe0;
    int          nre0;
    logic        oob;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        tab[0] = '{0, 1'b0, 16'd1,  16'h0000, 16'h0023, 2'b00};
        tab[1] = '{1, 1'b1, 16'd7,  16'hA5A5, 16'h0000, 2'b00};
        tab[2] = '{1, 1'b0, 16'd7,  16'h0000, 16'hA5A5, 2'b00};
        tab[3] = '{0, 1'b0, 16'd2,  16'h0000, 16'h0009, 2'b00};
        tab[4] = '{1, 1'b0, 16'd4,  16'h0000, 16'h00C9, 2'b00};
        tab[5] = '{0, 1'b1, 16'd0,  16'h1234, 16'h0000, 2'b00};
        tab[6] = '{0, 1'b0, 16'd0,  16'h0000, 16'h1234, 2'b00};
        tab[7] = '{1, 1'b0, 16'd23, 16'h0000, 16'h4017, 2'b00};
`ifdef DMEM_ARB_BOUNDS_EN
        tab[8] = '{0, 1'b0, 16'd24, 16'h0000, 16'h0000, 2'b01};
`else
        tab[8] = '{0, 1'b0, 16'd24, 16'h0000, 16'h4018, 2'b00};
`endif

        bus.req = 2'b00; bus.lock = 2'b00; bus.we = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",       32'(bus.gnt),       32'd0);
        chk("rst_ack",       32'(bus.ack),       32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_rdata",     32'(bus.rdata),     32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_re",    32'(bus.mem_re),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a write's ACC cycle aborts it.
        @(negedge clk);
        bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 16'd5; bus.wdata0 = 16'hBEEF;
        #1;
        chk("abort_gnt", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        chk("abort_acc_we",   32'(bus.mem_we),   32'd1);
        chk("abort_acc_addr", 32'(bus.mem_addr), 32'd5);
        chk("abort_acc_busy", 32'(bus.busy),     32'd1);
        rst_n   = 1'b0;
        bus.req = 2'b00; bus.we = 2'b00;
        #1;
        chk("abort_mem_we",    32'(bus.mem_we),    32'd0);
        chk("abort_busy",      32'(bus.busy),      32'd0);
        chk("abort_ack",       32'(bus.ack),       32'd0);
        chk("abort_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_word5", 32'(mem[5]), 32'h003C);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesting, no lock: accepts alternate 0,1,0,1 every 2 cycles.
        nre0 = n_re;
        nwe0 = n_we;
        order.delete();
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 2'b00, 2'b00, 16'd1, 16'd3, 16'h0, 16'h0, 1'b1, g);
            if (g != 2'b00) order.push_back((g == 2'b10) ? 1 : 0);
        end
        drive(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 1'b1, g);
        drain("alt_drain");
        chk("alt_accepts", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) chk("alt_order", 32'(order[i]), 32'(i % 2));
        chk("alt_re_cycles", 32'(n_re - nre0), 32'd4);
        chk("alt_we_cycles", 32'(n_we - nwe0), 32'd0);

        // Lock burst: requester 0 keeps priority for reads of 2,3,4 over requester 1.
        order.delete();
        kk   = 0;
        got1 = 1'b0;
        for (int n = 0; n < 16 && !(kk == 3 && got1); n++) begin
            drive({~got1, 1'(kk < 3)}, {1'b0, 1'(kk < 2)}, 2'b00,
                  16'(2 + kk), 16'd7, 16'h0, 16'h0, 1'b1, g);
            if (g == 2'b01) begin
                kk++;
                order.push_back(0);
            end else if (g == 2'b10) begin
                got1 = 1'b1;
                order.push_back(1);
            end
        end
        drive(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 1'b1, g);
        drain("lock_drain");
        chk("lock_accepts", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) chk("lock_order", 32'(order[i]), (i < 3) ? 32'd0 : 32'd1);

        // Single-transaction vector table.
        for (int i = 0; i < 9; i++) begin
            nwe0 = n_we;
            nre0 = n_re;
            got  = 1'b0;
            oob  = BOUNDS && (tab[i].addr >= 16'(DEPTH));
            for (int n = 0; n < 10 && !got; n++) begin
                drive((tab[i].id == 0) ? 2'b01 : 2'b10, 2'b00, {2{tab[i].we}},
                      tab[i].addr, tab[i].addr, tab[i].wdata, tab[i].wdata, 1'b0, g);
                if (g != 2'b00) begin
                    got = 1'b1;
                    push_raw((tab[i].id == 0) ? 2'b01 : 2'b10, tab[i].exp_rdata, tab[i].exp_err);
                end
            end
            chk("vec_accept", 32'(got), 32'd1);
            drive(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 1'b0, g);
            drain("vec_drain");
            chk("vec_we_cycles", 32'(n_we - nwe0), (tab[i].we && !oob) ? 32'd1 : 32'd0);
            chk("vec_re_cycles", 32'(n_re - nre0), (!tab[i].we && !oob) ? 32'd1 : 32'd0);
        end
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer sharing the single-port 16-bit data memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader).
- Round-robin grants, with an optional per-requester lock for back-to-back bursts.
- Drives the memory's write-enable, read-enable, address and write-data; captures the combinational read data into a register; returns a one-cycle acknowledge to the requester.

Parameters:
- DEPTH, 24, number of implemented memory words (valid addresses 0..DEPTH-1)
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request per requester; command fields held stable while high
- lock  in  2  keep priority after the current accept
- we  in  2  1 = write, 0 = read, per requester
- addr0  in  AW  requester 0 address
- addr1  in  AW  requester 1 address
- wdata0  in  DW  requester 0 write data
- wdata1  in  DW  requester 1 write data
- gnt  out  2  combinational grant; accept = req[i]&gnt[i] at rising edge
- ack  out  2  one-cycle completion pulse
- rdata  out  DW  registered read data, valid while ack
- err  out  2  out-of-range flag, valid while ack
- busy  out  1  state != IDLE
- mem_addr  out  AW  to memory
- mem_wdata  out  DW  to memory
- mem_we  out  1  to memory
- mem_re  out  1  to memory
- mem_rdata  in  DW  combinational read data from memory

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0, owner=0.
  - gnt=0, ack=0, err=0, rdata=0, busy=0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - mem_we drops immediately; an in-flight write is aborted if reset precedes the ACC edge.
- FSM states: IDLE, ACC, RESP.
- Grant selection:
  - gnt is nonzero only in IDLE or RESP; at most one bit is set.
  - Winner = rr_ptr if req[rr_ptr], else the other requester if it is requesting.
- IDLE:
  - On accept: latch owner, we, addr and wdata into command registers; go to ACC.
  - No request: stay in IDLE.
- ACC (exactly one cycle):
  - mem_addr/mem_wdata come from the command registers.
  - mem_we = cmd_we; mem_re = ~cmd_we.
  - At the closing edge: the write commits in memory; for a read, rdata <= mem_rdata; for a write, rdata <= 0.
  - Go to RESP.
- RESP (one cycle):
  - ack[owner]=1; mem_we=0; mem_re=0; mem_addr/mem_wdata hold their values.
  - gnt is evaluated as in IDLE. On accept, the next command is latched and the FSM goes to ACC. Otherwise go to IDLE.
- Latency and throughput:
  - Accept at edge N; memory access during cycle N+1; ack during cycle N+2.
  - Sustained throughput is one access per 2 cycles.
- Round-robin pointer:
  - On each accept by requester i: rr_ptr <= i if lock[i], else rr_ptr <= ~i.
- Requester rules:
  - A requester drops req, or presents its next command, in the cycle after its accept edge.
  - A request held high after accept is treated as a new command.
- Simultaneous requests: the rr_ptr holder wins; the loser keeps gnt=0 and waits. With lock deasserted, the loser wins the next accept.
- Address range: addresses >= DEPTH are passed to memory unchanged unless DMEM_ARB_BOUNDS_EN is defined.
- rdata holds its value outside ack; it is only meaningful while ack is high.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_EN.
- Defined: a command with addr >= DEPTH is still accepted and sequenced, but during ACC mem_we=0 and mem_re=0; rdata <= 0 and err[owner]=1 with ack.
- Undefined: no range check; err is tied to 0; the access goes to memory as issued.

Test Plan:
- Reset with rst_n low mid-ACC of a write (req0, we=1, addr=5, wdata=16'hBEEF) -> mem_we drops immediately; word 5 keeps its initial value 16'h003C; all outputs return to 0.
- Read via req0 of addr=1 with memory preloaded -> ack[0] two cycles after accept, rdata=16'h0023, err=0.
- Write via req1 (addr=7, wdata=16'hA5A5) then read via req1 of addr 7 -> second ack returns rdata=16'hA5A5; mem_we high exactly one cycle.
- req0 and req1 held continuously, lock=0 -> accepts alternate 0,1,0,1 starting from rr_ptr=0; one ack every 2 cycles.
- req0 with lock[0]=1 for 3 reads (addr 2,3,4) while req1 is also high -> three consecutive req0 accepts returning 16'h0009, 16'h0031, 16'h00C9; req1 is served after lock[0] drops.
- Define DMEM_ARB_BOUNDS_EN; read addr=24 -> mem_re never asserted; ack with err=1 and rdata=0. Without the macro, err stays 0.
